// File: rtl/famicom_pad_responder.sv
// famicom_pad_responder
//   Emulates the 4021 shift-register side of a Famicom/NES game pad. The
//   console's latch and pulse strobes arrive asynchronously to clk and are
//   synchronised, together with the button vector, before an edge-driven
//   FSM loads and shifts an active-low copy of the buttons out on
//   famicom_data.
//
// Parameters
//   SYNC_STAGES   synchroniser depth on latch, pulse and buttons (2..4)
//   FILL_BIT      level shifted in at the top once the 8 button bits are out
//   STALE_CYCLES  clk cycles without a latch rise before pad_stale is raised
//
// Ports
//   clk            50 MHz system clock
//   reset_n        asynchronous active-low reset
//   buttons[7:0]   pressed=1: A, B, Select, Start, Up, Down, Left, Right
//   famicom_latch  parallel-load strobe from the console (async)
//   famicom_pulse  shift clock from the console (async)
//   famicom_data   registered serial data, active-low (0 = pressed)
//   read_complete  one-cycle pulse when the 8th bit has been shifted out
//   poll_count     number of latch rising edges seen, wrapping
//   pad_stale      high while no latch rise has been seen for STALE_CYCLES
module famicom_pad_responder #(
  parameter int   SYNC_STAGES  = 2,
  parameter logic FILL_BIT     = 1'b0,
  parameter int   STALE_CYCLES = 2_500_000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  buttons,
  input  logic        famicom_latch,
  input  logic        famicom_pulse,
  output logic        famicom_data,
  output logic        read_complete,
  output logic [15:0] poll_count,
  output logic        pad_stale
);

  localparam int                 STALE_W   = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);
  localparam logic [STALE_W-1:0] STALE_ONE = STALE_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_t;

  // ---------------------------------------------------------------------
  // Synchronisers. Stage 0 samples the pin; the last stage is the
  // synchronised level. One further copy of latch/pulse feeds edge detect.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] latch_sync;
  logic [SYNC_STAGES-1:0] pulse_sync;
  logic [7:0]             btn_sync [SYNC_STAGES];
  logic                   latch_d;
  logic                   pulse_d;

  logic                   latch_s;
  logic                   pulse_s;
  logic [7:0]             buttons_s;
  logic                   latch_rise;
  logic                   pulse_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      latch_sync <= '0;
      pulse_sync <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        btn_sync[i] <= '0;
      end
      latch_d <= 1'b0;
      pulse_d <= 1'b0;
    end else begin
      latch_sync <= {latch_sync[SYNC_STAGES-2:0], famicom_latch};
      pulse_sync <= {pulse_sync[SYNC_STAGES-2:0], famicom_pulse};
      btn_sync[0] <= buttons;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        btn_sync[i] <= btn_sync[i-1];
      end
      latch_d <= latch_sync[SYNC_STAGES-1];
      pulse_d <= pulse_sync[SYNC_STAGES-1];
    end
  end

  assign latch_s    = latch_sync[SYNC_STAGES-1];
  assign pulse_s    = pulse_sync[SYNC_STAGES-1];
  assign buttons_s  = btn_sync[SYNC_STAGES-1];
  assign latch_rise = latch_s & ~latch_d;
  assign pulse_rise = pulse_s & ~pulse_d;

  // ---------------------------------------------------------------------
  // Load/shift FSM
  // ---------------------------------------------------------------------
  state_t     state;
  state_t     state_n;
  logic [7:0] shift_reg;
  logic [7:0] shift_n;
  logic [7:0] shifted;
  logic [3:0] bit_cnt;
  logic [3:0] bit_cnt_n;
  logic       read_complete_n;

  assign shifted = {FILL_BIT, shift_reg[7:1]};

  always_comb begin
    state_n         = state;
    shift_n         = shift_reg;
    bit_cnt_n       = bit_cnt;
    read_complete_n = 1'b0;

    if (latch_s) begin
      // Latch high wins over everything, including a coincident pulse edge.
      // Reloading every cycle keeps the buttons transparent like the 4021.
      state_n   = LOAD;
      shift_n   = ~buttons_s;
      bit_cnt_n = '0;
    end else begin
      unique case (state)
        IDLE: begin
          // Pad not latched yet: shifts like a real register, but is not a read.
          if (pulse_rise) begin
            shift_n = shifted;
          end
        end
        // The cycle latch_s falls is already the first cycle of the read, so
        // LOAD shares SHIFT's handling instead of dropping a pulse edge.
        LOAD, SHIFT: begin
          state_n = SHIFT;
          if (pulse_rise) begin
            shift_n   = shifted;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              read_complete_n = 1'b1;
              state_n         = DONE;
            end
          end
        end
        DONE: begin
          // Overshift: keep emitting FILL_BIT; bit_cnt holds at 8.
          if (pulse_rise) begin
            shift_n = shifted;
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      shift_reg     <= 8'hFF;
      bit_cnt       <= '0;
      read_complete <= 1'b0;
    end else begin
      state         <= state_n;
      shift_reg     <= shift_n;
      bit_cnt       <= bit_cnt_n;
      read_complete <= read_complete_n;
    end
  end

  // Registered output: no combinational path from the pins to the console.
  assign famicom_data = shift_reg[0];

  // ---------------------------------------------------------------------
  // Poll counter and staleness monitor
  // ---------------------------------------------------------------------
  logic [STALE_W-1:0] stale_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      poll_count <= '0;
      stale_cnt  <= '0;
      pad_stale  <= 1'b1;
    end else begin
      if (latch_rise) begin
        poll_count <= poll_count + 16'd1;
      end

      if (latch_rise) begin
        stale_cnt <= '0;
        pad_stale <= 1'b0;
      end else if (stale_cnt != STALE_MAX) begin
        stale_cnt <= stale_cnt + STALE_ONE;
        // Flag on the same edge the counter reaches STALE_MAX.
        if (stale_cnt == STALE_MAX - STALE_ONE) begin
          pad_stale <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_famicom_pad_responder.sv
`timescale 1ns/1ps
module tb_famicom_pad_responder;

  localparam logic [2:0] K_DATA  = 3'd0;
  localparam logic [2:0] K_POLL  = 3'd1;
  localparam logic [2:0] K_STALE = 3'd2;
  localparam logic [2:0] K_RCCNT = 3'd3;
  localparam logic [2:0] K_RCLAT = 3'd4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  buttons;
  logic        famicom_latch;
  logic        famicom_pulse;
  logic        famicom_data;
  logic        read_complete;
  logic [15:0] poll_count;
  logic        pad_stale;

  always #5 clk = ~clk;

  famicom_pad_responder #(
    .SYNC_STAGES (2),
    .FILL_BIT    (1'b0),
    .STALE_CYCLES(100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .buttons      (buttons),
    .famicom_latch(famicom_latch),
    .famicom_pulse(famicom_pulse),
    .famicom_data (famicom_data),
    .read_complete(read_complete),
    .poll_count   (poll_count),
    .pad_stale    (pad_stale)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] exp;
  } item_t;

  item_t exp_q[$];
  int    checks    = 0;
  int    errors    = 0;
  int    cyc       = 0;
  int    pulse_cyc = 0;
  int    rc_count  = 0;
  int    rc_lat    = 0;
  logic  req       = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input logic [2:0] k);
    case (k)
      K_DATA:  return "famicom_data";
      K_POLL:  return "poll_count";
      K_STALE: return "pad_stale";
      K_RCCNT: return "read_complete_count";
      default: return "read_complete_latency";
    endcase
  endfunction

  function automatic logic [15:0] actual(input logic [2:0] k);
    case (k)
      K_DATA:  return {15'd0, famicom_data};
      K_POLL:  return poll_count;
      K_STALE: return {15'd0, pad_stale};
      K_RCCNT: return 16'(rc_count);
      default: return 16'(rc_lat);
    endcase
  endfunction

  // Monitor: counts read_complete pulses, and on each sample request pops
  // every pending expectation and compares it against the DUT.
  item_t       it;
  logic [15:0] act;
  always @(negedge clk) begin
    if (read_complete === 1'b1) begin
      rc_count = rc_count + 1;
      rc_lat   = cyc - pulse_cyc;
    end
    if (req) begin
      while (exp_q.size() > 0) begin
        it  = exp_q.pop_front();
        act = actual(it.kind);
        checks = checks + 1;
        if (act !== it.exp) begin
          errors = errors + 1;
          $display("FAIL %s: got %0h required %0h (cycle %0d)",
                   kname(it.kind), act, it.exp, cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] k, input logic [15:0] e);
    item_t x;
    x.kind = k;
    x.exp  = e;
    exp_q.push_back(x);
  endtask

  task automatic sample();
    req = 1'b1;
    @(negedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic pulse_bit();
    tick();
    famicom_pulse = 1'b1;
    pulse_cyc     = cyc;
    repeat (4) tick();
    famicom_pulse = 1'b0;
    repeat (4) tick();
  endtask

  task automatic load(input logic [7:0] b);
    tick();
    buttons = b;
    tick();
    famicom_latch = 1'b1;
    repeat (10) tick();
    famicom_latch = 1'b0;
    repeat (4) tick();
  endtask

  task automatic read_bits(input int n, input logic [7:0] e);
    for (int i = 0; i < n; i++) begin
      push(K_DATA, {15'd0, e[i]});
      sample();
      pulse_bit();
    end
  endtask

  initial begin
    reset_n       = 1'b0;
    famicom_latch = 1'b0;
    famicom_pulse = 1'b0;
    buttons       = 8'h00;

    push(K_DATA, 16'd1);
    push(K_POLL, 16'd0);
    push(K_STALE, 16'd1);
    push(K_RCCNT, 16'd0);
    sample();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) pulse_bit();
    push(K_DATA, 16'd1);
    sample();
    pulse_bit();
    push(K_DATA, 16'd0);
    push(K_RCCNT, 16'd0);
    sample();

    tick();
    famicom_latch = 1'b1;
    repeat (102) @(posedge clk);
    push(K_STALE, 16'd0);
    sample();
    @(posedge clk);
    push(K_STALE, 16'd1);
    sample();
    famicom_latch = 1'b0;
    repeat (4) tick();
    push(K_POLL, 16'd1);
    sample();

    load(8'b0000_1001);
    push(K_POLL, 16'd2);
    sample();
    read_bits(8, 8'b1111_0110);
    push(K_RCCNT, 16'd1);
    push(K_RCLAT, 16'd3);
    push(K_DATA, 16'd0);
    sample();

    for (int i = 0; i < 4; i++) begin
      pulse_bit();
      push(K_DATA, 16'd0);
      sample();
    end
    push(K_RCCNT, 16'd1);
    sample();

    load(8'h00);
    read_bits(3, 8'hFF);
    load(8'hFF);
    push(K_RCCNT, 16'd1);
    push(K_POLL, 16'd4);
    sample();
    read_bits(8, 8'h00);
    push(K_RCCNT, 16'd2);
    push(K_RCLAT, 16'd3);
    push(K_DATA, 16'd0);
    sample();

    load(8'b0000_0011);
    read_bits(2, 8'b1111_1100);
    buttons = 8'b0101_0101;
    repeat (2) tick();
    famicom_latch = 1'b1;
    famicom_pulse = 1'b1;
    tick();
    famicom_latch = 1'b0;
    repeat (3) tick();
    famicom_pulse = 1'b0;
    repeat (5) tick();
    push(K_POLL, 16'd6);
    sample();
    read_bits(7, 8'b1010_1010);
    push(K_RCCNT, 16'd2);
    push(K_DATA, 16'd1);
    sample();
    pulse_bit();
    push(K_RCCNT, 16'd3);
    push(K_RCLAT, 16'd3);
    push(K_DATA, 16'd0);
    sample();

    tick();
    buttons       = 8'h00;
    famicom_latch = 1'b1;
    repeat (6) tick();
    buttons = 8'h01;
    repeat (2) @(posedge clk);
    push(K_DATA, 16'd1);
    sample();
    @(posedge clk);
    push(K_DATA, 16'd0);
    sample();
    buttons = 8'h00;
    repeat (2) @(posedge clk);
    push(K_DATA, 16'd0);
    sample();
    @(posedge clk);
    push(K_DATA, 16'd1);
    sample();
    famicom_latch = 1'b0;
    repeat (4) tick();
    push(K_POLL, 16'd7);
    sample();

    load(8'hFF);
    read_bits(3, 8'h00);
    push(K_POLL, 16'd8);
    sample();
    tick();
    reset_n = 1'b0;
    #1;
    checks = checks + 1;
    if (famicom_data !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL async famicom_data: got %0b required 1 (cycle %0d)", famicom_data, cyc);
    end
    checks = checks + 1;
    if (poll_count !== 16'd0) begin
      errors = errors + 1;
      $display("FAIL async poll_count: got %0h required 0 (cycle %0d)", poll_count, cyc);
    end
    checks = checks + 1;
    if (pad_stale !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL async pad_stale: got %0b required 1 (cycle %0d)", pad_stale, cyc);
    end
    push(K_DATA, 16'd1);
    push(K_POLL, 16'd0);
    push(K_STALE, 16'd1);
    sample();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    load(8'b1010_0110);
    read_bits(8, 8'b0101_1001);
    push(K_RCCNT, 16'd4);
    push(K_POLL, 16'd1);
    push(K_RCLAT, 16'd3);
    push(K_DATA, 16'd0);
    sample();

    for (int i = 0; i < 65534; i++) begin
      famicom_latch = 1'b1;
      tick();
      famicom_latch = 1'b0;
      tick();
    end
    repeat (4) tick();
    push(K_POLL, 16'hFFFF);
    sample();
    famicom_latch = 1'b1;
    tick();
    famicom_latch = 1'b0;
    repeat (4) tick();
    push(K_POLL, 16'h0000);
    push(K_STALE, 16'd0);
    push(K_RCCNT, 16'd4);
    sample();
    checks = checks + 1;
    if (poll_count !== 16'h0000) begin
      errors = errors + 1;
      $display("FAIL wrap poll_count: got %0h required 0 (cycle %0d)", poll_count, cyc);
    end
    checks = checks + 1;
    if (pad_stale !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL wrap pad_stale: got %0b required 0 (cycle %0d)", pad_stale, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    errors = errors + 1;
    $display("FAIL watchdog: got timeout required completion (cycle %0d)", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
